// File: rtl/pwm_capture_pkg.sv
// Shared motor-control definitions: capture FSM encoding, duty width and the
// PWM register power-up duty value (also used by the PWM generator).
package pwm_capture_pkg;

  localparam int unsigned DUTY_W   = 8;
  localparam logic [7:0]  DUTY_RST = 8'h80;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_capture_div.sv
// Restoring divider for the duty ratio: quot = floor(num / den), 8 quotient
// bits, one per clk after a single load cycle. Saturates to all-ones when the
// integer part of num (its upper CNTW bits) is not below den.
// Ports: clk, resetn (async active-low), start (load pulse), abort (drop the
// division in flight), num {hightime,8'h00}, den period, busy, quot, done.
module pwm_capture_div
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNTW+DUTY_W-1:0]   num,
  input  logic [CNTW-1:0]          den,
  output logic                     busy,
  output logic [DUTY_W-1:0]        quot,
  output logic                     done
);

  logic [CNTW-1:0]   rem;
  logic [CNTW-1:0]   dreg;
  logic [DUTY_W-1:0] lo;
  logic [DUTY_W-2:0] q;
  logic [3:0]        cnt;
  logic              sat;
  logic [CNTW:0]     trial_c;
  logic              ge_c;

  // Partial remainder shifted left with the next numerator bit.
  always_comb begin
    trial_c = {rem, lo[DUTY_W-1]};
    ge_c    = trial_c >= {1'b0, dreg};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem  <= '0;
      dreg <= '0;
      lo   <= '0;
      q    <= '0;
      cnt  <= '0;
      sat  <= 1'b0;
      busy <= 1'b0;
      quot <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (start) begin
        rem  <= num[CNTW+DUTY_W-1:DUTY_W];
        lo   <= num[DUTY_W-1:0];
        dreg <= den;
        sat  <= num[CNTW+DUTY_W-1:DUTY_W] >= den;
        cnt  <= 4'(DUTY_W);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= ge_c ? CNTW'(trial_c - {1'b0, dreg}) : trial_c[CNTW-1:0];
        lo  <= {lo[DUTY_W-2:0], 1'b0};
        q   <= {q[DUTY_W-3:0], ge_c};
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
          quot <= sat ? '1 : {q, ge_c};
        end
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures high time and period of pwmin in sampce ticks,
// derives an 8-bit duty ratio and flags stuck-high / stuck-low / overrun.
// Ports: clk, resetn (async active-low), sampce (sample enable), pwmin
// (async input), invertpwm, clrstat (clear sticky flags); outputs hightime,
// period, duty, dutyvalid (update pulse), stuckhi, stucklo, overrun.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNTW = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sampce,
  input  logic              pwmin,
  input  logic              invertpwm,
  input  logic              clrstat,
  output logic [CNTW-1:0]   hightime,
  output logic [CNTW-1:0]   period,
  output logic [DUTY_W-1:0] duty,
  output logic              dutyvalid,
  output logic              stuckhi,
  output logic              stucklo,
  output logic              overrun
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  cap_state_t        state;
  logic              s1, s2, v1, v2, prev, primed;
  logic [CNTW-1:0]   hcnt, pcnt, hlat, hpend, ppend;
  logic              pwms_c, samp_c, rise_c, fall_c;
  logic              tmo_c, tmo_hi_c, tmo_lo_c, pdone_c, start_c, ovr_c;
  logic              div_busy, div_done;
  logic [DUTY_W-1:0] div_quot;

  // Edge/timeout qualification; edges only count once the sync chain is primed.
  always_comb begin
    pwms_c   = s2 ^ invertpwm;
    samp_c   = sampce & primed;
    rise_c   = samp_c & pwms_c & ~prev;
    fall_c   = samp_c & ~pwms_c & prev;
    tmo_c    = samp_c & (state != ST_SYNC) & (pcnt == CNT_MAX);
    tmo_hi_c = tmo_c & (state == ST_HIGH);
    tmo_lo_c = tmo_c & (state == ST_LOW);
    pdone_c  = rise_c & (state == ST_LOW) & ~tmo_c;
    start_c  = pdone_c & ~div_busy;
    ovr_c    = pdone_c & div_busy;
  end

  // Two-flop synchronizer; v1/v2 mark when s2 holds real post-reset data so a
  // level already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      s1 <= pwmin;
      s2 <= s1;
      v1 <= 1'b1;
      v2 <= v1;
      if (sampce) begin
        prev   <= pwms_c;
        primed <= primed | v2;
      end
    end
  end

  // Measurement FSM; timeout takes priority over any edge in the same sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_SYNC;
      hcnt  <= '0;
      pcnt  <= '0;
      hlat  <= '0;
    end else if (samp_c) begin
      case (state)
        ST_SYNC: begin
          if (rise_c) begin
            hcnt  <= CNTW'(1);
            pcnt  <= CNTW'(1);
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (tmo_c) begin
            state <= ST_SYNC;
          end else if (fall_c) begin
            hlat  <= hcnt;
            pcnt  <= pcnt + CNTW'(1);
            state <= ST_LOW;
          end else begin
            hcnt <= hcnt + CNTW'(1);
            pcnt <= pcnt + CNTW'(1);
          end
        end
        ST_LOW: begin
          if (tmo_c) begin
            state <= ST_SYNC;
          end else if (rise_c) begin
            hcnt  <= CNTW'(1);
            pcnt  <= CNTW'(1);
            state <= ST_HIGH;
          end else begin
            pcnt <= pcnt + CNTW'(1);
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

  // Snapshot of the measurement being divided, published together with duty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hpend <= '0;
      ppend <= '0;
    end else if (start_c) begin
      hpend <= hlat;
      ppend <= pcnt;
    end
  end

  pwm_capture_div #(.CNTW(CNTW)) u_div (
    .clk    (clk),
    .resetn (resetn),
    .start  (start_c),
    .abort  (tmo_c),
    .num    ({hlat, 8'h00}),
    .den    (pcnt),
    .busy   (div_busy),
    .quot   (div_quot),
    .done   (div_done)
  );

  // Result registers: timeout results override a division finishing together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hightime  <= '0;
      period    <= '0;
      duty      <= DUTY_RST;
      dutyvalid <= 1'b0;
    end else begin
      dutyvalid <= 1'b0;
      if (tmo_hi_c) begin
        hightime  <= CNT_MAX;
        period    <= CNT_MAX;
        duty      <= 8'hFF;
        dutyvalid <= 1'b1;
      end else if (tmo_lo_c) begin
        hightime  <= '0;
        period    <= CNT_MAX;
        duty      <= 8'h00;
        dutyvalid <= 1'b1;
      end else if (div_done) begin
        hightime  <= hpend;
        period    <= ppend;
        duty      <= div_quot;
        dutyvalid <= 1'b1;
      end
    end
  end

  // Sticky flags: a set in the clearing cycle wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stuckhi <= 1'b0;
      stucklo <= 1'b0;
      overrun <= 1'b0;
    end else begin
      stuckhi <= (stuckhi & ~clrstat) | tmo_hi_c;
      stucklo <= (stucklo & ~clrstat) | tmo_lo_c;
      overrun <= (overrun & ~clrstat) | ovr_c;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: sample-level reference model of the capture rules,
// compared against the DUT on every falling clk edge, plus literal checks.
module tb_pwm_capture;

  localparam int unsigned CNTW = 16;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            clk       = 1'b0;
  logic            resetn    = 1'b0;
  logic            sampce    = 1'b1;
  logic            pwmin     = 1'b0;
  logic            invertpwm = 1'b0;
  logic            clrstat   = 1'b0;
  logic [CNTW-1:0] hightime, period;
  logic [7:0]      duty;
  logic            dutyvalid, stuckhi, stucklo, overrun;

  int vectors     = 0;
  int miscompares = 0;
  bit rnd_sce     = 1'b0;

  always #5 clk = ~clk;

  pwm_capture #(.CNTW(CNTW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sampce    (sampce),
    .pwmin     (pwmin),
    .invertpwm (invertpwm),
    .clrstat   (clrstat),
    .hightime  (hightime),
    .period    (period),
    .duty      (duty),
    .dutyvalid (dutyvalid),
    .stuckhi   (stuckhi),
    .stucklo   (stucklo),
    .overrun   (overrun)
  );

  // Reference model state.
  longint ecyc = 0;
  bit     m_d1, m_d2, m_prev, m_primed, m_pend;
  int     m_ne, m_mode, m_h, m_p, m_hsave;
  longint m_due;
  int     m_ph, m_pp, m_pduty;
  int     e_ht, e_pd, e_duty;
  bit     e_dv, e_shi, e_slo, e_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, ecyc, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 0; m_d2 = 0; m_prev = 0; m_primed = 0; m_pend = 0;
    m_ne = 0; m_mode = 0; m_h = 0; m_p = 0; m_hsave = 0;
    e_ht = 0; e_pd = 0; e_duty = 'h80; e_dv = 0;
    e_shi = 0; e_slo = 0; e_ovr = 0;
  endtask

  // Effect of the coming rising clk edge given the inputs now applied.
  task automatic model_step();
    bit lvl, valid, rise, fall, shi_set, slo_set, ovr_set;
    shi_set = 0; slo_set = 0; ovr_set = 0;
    ecyc++;
    e_dv = 0;
    if (m_pend && ecyc == m_due) begin
      e_ht = m_ph; e_pd = m_pp; e_duty = m_pduty; e_dv = 1; m_pend = 0;
    end
    valid = (m_ne >= 2);
    lvl   = m_d2 ^ invertpwm;
    m_d2  = m_d1;
    m_d1  = pwmin;
    if (m_ne < 2) m_ne++;
    if (sampce && valid) begin
      if (m_primed) begin
        rise = lvl && !m_prev;
        fall = !lvl && m_prev;
        case (m_mode)
          0: if (rise) begin m_h = 1; m_p = 1; m_mode = 1; end
          1: begin
            if (m_p == MAXC) begin
              e_ht = MAXC; e_pd = MAXC; e_duty = 255; e_dv = 1;
              m_pend = 0; shi_set = 1; m_mode = 0;
            end else if (fall) begin
              m_hsave = m_h; m_p++; m_mode = 2;
            end else begin
              m_h++; m_p++;
            end
          end
          default: begin
            if (m_p == MAXC) begin
              e_ht = 0; e_pd = MAXC; e_duty = 0; e_dv = 1;
              m_pend = 0; slo_set = 1; m_mode = 0;
            end else if (rise) begin
              if (m_pend) ovr_set = 1;
              else begin
                m_pend = 1; m_due = ecyc + 9;
                m_ph = m_hsave; m_pp = m_p;
                m_pduty = (m_hsave * 256) / m_p;
                if (m_pduty > 255) m_pduty = 255;
              end
              m_h = 1; m_p = 1; m_mode = 1;
            end else begin
              m_p++;
            end
          end
        endcase
      end
      m_prev = lvl;
      m_primed = 1;
    end
    e_shi = (e_shi && !clrstat) || shi_set;
    e_slo = (e_slo && !clrstat) || slo_set;
    e_ovr = (e_ovr && !clrstat) || ovr_set;
  endtask

  // Compare DUT state after the last rising edge, then advance the model.
  always @(negedge clk) begin
    if (!resetn) model_reset();
    chk("dutyvalid", 32'(dutyvalid), 32'(e_dv));
    chk("hightime",  32'(hightime),  32'(e_ht));
    chk("period",    32'(period),    32'(e_pd));
    chk("duty",      32'(duty),      32'(e_duty));
    chk("stuckhi",   32'(stuckhi),   32'(e_shi));
    chk("stucklo",   32'(stucklo),   32'(e_slo));
    chk("overrun",   32'(overrun),   32'(e_ovr));
    if (resetn) model_step();
  end

  task automatic step(input bit p);
    @(posedge clk);
    #1;
    pwmin   = p;
    sampce  = rnd_sce ? ($urandom_range(0, 3) != 0) : 1'b1;
    clrstat = rnd_sce && ($urandom_range(0, 49) == 0);
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hi; i++) step(1'b1);
      for (int i = 0; i < lo; i++) step(1'b0);
    end
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1; clrstat = 1'b1;
    @(posedge clk); #1; clrstat = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hightime", 32'(hightime), 32'd0);
    chk("rst_period",   32'(period),   32'd0);
    chk("rst_duty",     32'(duty),     32'h80);
    chk("rst_dutyvalid",32'(dutyvalid),32'd0);
    resetn = 1'b1;

    // 64 high / 192 low
    wave(64, 192, 4);
    chk("q25_hightime", 32'(hightime), 32'd64);
    chk("q25_period",   32'(period),   32'd256);
    chk("q25_duty",     32'(duty),     32'h40);

    // 128/128 through the inverter
    invertpwm = 1'b1;
    wave(128, 128, 4);
    chk("inv_hightime", 32'(hightime), 32'd128);
    chk("inv_duty",     32'(duty),     32'h80);

    // 1 high / 255 low
    invertpwm = 1'b0;
    wave(1, 255, 4);
    chk("min_hightime", 32'(hightime), 32'd1);
    chk("min_duty",     32'(duty),     32'h01);

    // 6-clk period outruns the divider
    wave(3, 3, 20);
    chk("ovr_flag",     32'(overrun),  32'd1);
    chk("ovr_duty",     32'(duty),     32'h80);
    chk("ovr_period",   32'(period),   32'd6);
    pulse_clr();
    chk("ovr_clr",      32'(overrun),  32'd0);

    // randomized periods, sample enable and flag clears
    rnd_sce = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) == 0) invertpwm = ~invertpwm;
      wave(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
    end
    for (int k = 0; k < 40; k++)
      wave(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), 1);
    rnd_sce = 1'b0;
    invertpwm = 1'b0;
    wave(64, 192, 2);

    // reset pulse in the middle of a high phase
    for (int i = 0; i < 30; i++) step(1'b1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_hightime", 32'(hightime), 32'd0);
    chk("mid_rst_period",   32'(period),   32'd0);
    chk("mid_rst_duty",     32'(duty),     32'h80);
    chk("mid_rst_overrun",  32'(overrun),  32'd0);
    for (int i = 0; i < 3; i++) step(1'b1);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1);
    wave(64, 192, 3);
    chk("post_rst_hightime", 32'(hightime), 32'd64);

    // stuck high
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 70000; i++) step(1'b1);
    chk("stuck_flag",     32'(stuckhi),  32'd1);
    chk("stuck_duty",     32'(duty),     32'hFF);
    chk("stuck_period",   32'(period),   32'hFFFF);
    chk("stuck_hightime", 32'(hightime), 32'hFFFF);
    pulse_clr();
    chk("stuck_clr",      32'(stuckhi),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
